// File: rtl/ir_pulse_tx.sv
// ir_pulse_tx: pulse-width IR transmitter; each bit is a low mark followed by a high space whose
// length encodes the bit, closed by a final mark and a long stop space. IR_TX_CARRIER_EN adds led_out.
module ir_pulse_tx #(
    parameter int DATA_W       = 8,
    parameter int MARK_CYC     = 200,
    parameter int SPACE0_CYC   = 500,
    parameter int SPACE1_CYC   = 1400,
    parameter int STOP_CYC     = 2400,
    parameter int CARRIER_HALF = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              ir_out,
    output logic              busy,
    output logic              done
`ifdef IR_TX_CARRIER_EN
    ,
    output logic              led_out
`endif
);
    typedef enum logic [1:0] {IDLE, MARK, SPACE, STOP} state_t;
    localparam int RW = $clog2(DATA_W + 1);
    localparam logic [31:0] MARK_LAST   = 32'(MARK_CYC - 1);
    localparam logic [31:0] SPACE0_LAST = 32'(SPACE0_CYC - 1);
    localparam logic [31:0] SPACE1_LAST = 32'(SPACE1_CYC - 1);
    localparam logic [31:0] STOP_LAST   = 32'(STOP_CYC - 1);

    // Widths must fall inside the far-end receiver's decode bands.
    if (MARK_CYC < 1 || SPACE0_CYC < 1 || SPACE0_CYC > 1000 || SPACE1_CYC <= 1001 || SPACE1_CYC > 1800 ||
        STOP_CYC <= 1801 || STOP_CYC > 177127 || CARRIER_HALF < 1) begin : g_bad_param
        $error("ir_pulse_tx: pulse widths outside receiver thresholds");
    end

    state_t            state;
    logic [31:0]       cnt;
    logic [DATA_W-1:0] sh;
    logic [RW-1:0]     rem;
    logic [31:0]       space_last;
    logic              mark_end;
    logic              space_end;
    logic              stop_end;

    assign space_last = sh[DATA_W-1] ? SPACE1_LAST : SPACE0_LAST;
    assign mark_end   = state == MARK && cnt == MARK_LAST;
    assign space_end  = state == SPACE && cnt == space_last;
    assign stop_end   = state == STOP && cnt == STOP_LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            rem      <= '0;
            ir_out   <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= (state == IDLE || mark_end || space_end || stop_end) ? '0 : cnt + 32'd1;
            case (state)
                IDLE: if (tx_valid) begin
                    state    <= MARK;
                    sh       <= tx_data;
                    rem      <= RW'(DATA_W);
                    ir_out   <= 1'b0;
                    tx_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                MARK: if (mark_end) begin
                    state  <= rem != '0 ? SPACE : STOP;
                    ir_out <= 1'b1;
                end
                SPACE: if (space_end) begin
                    state  <= MARK;
                    sh     <= sh << 1;
                    rem    <= rem - RW'(1);
                    ir_out <= 1'b0;
                end
                STOP: if (stop_end) begin
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IR_TX_CARRIER_EN
    localparam logic [31:0] HALF_LAST = 32'(CARRIER_HALF - 1);
    logic [31:0] ccnt;
    logic        mark_entry;

    assign mark_entry = (state == IDLE && tx_valid) || space_end;

    // Carrier restarts high on every mark so each burst has the same phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= 1'b0;
            ccnt    <= '0;
        end else if (mark_entry) begin
            led_out <= 1'b1;
            ccnt    <= '0;
        end else if (state != MARK || mark_end) begin
            led_out <= 1'b0;
            ccnt    <= '0;
        end else if (ccnt == HALF_LAST) begin
            led_out <= ~led_out;
            ccnt    <= '0;
        end else begin
            ccnt <= ccnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ir_pulse_tx.sv
// tb_ir_pulse_tx: frame-level reference model queues expected mark/space widths and decoded words;
// a negedge monitor measures ir_out runs, decodes them like the far-end receiver and compares.
module tb_ir_pulse_tx;
    localparam int DW = 8;
    localparam int M  = 8;
    localparam int S0 = 20;
    localparam int S1 = 1002;
    localparam int ST = 1802;
    localparam int CH = 3;

    typedef struct {
        logic lvl;
        int   len;
        logic last;
    } seg_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready;
    logic          ir_out;
    logic          busy;
    logic          done;
`ifdef IR_TX_CARRIER_EN
    logic          led_out;
`endif

    ir_pulse_tx #(
        .DATA_W(DW), .MARK_CYC(M), .SPACE0_CYC(S0), .SPACE1_CYC(S1), .STOP_CYC(ST), .CARRIER_HALF(CH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .ir_out(ir_out),
        .busy(busy),
        .done(done)
`ifdef IR_TX_CARRIER_EN
        ,
        .led_out(led_out)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    seg_t exp_q[$];
    logic [DW-1:0] data_q[$];
    int m_left = 0;
    int n_acc = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference model: a frame occupies the sum of its phase widths, then one done/ready cycle.
    always @(posedge clk) begin : model
        int total;
        int sp;
        if (!reset_n) begin
            m_left = 0;
            exp_q.delete();
            data_q.delete();
        end else begin
            if (m_left > 0) m_left--;
            if (m_left == 0 && tx_valid) begin
                total = 0;
                for (int i = DW - 1; i >= 0; i--) begin
                    sp = tx_data[i] ? S1 : S0;
                    exp_q.push_back(seg_t'{1'b0, M, 1'b0});
                    exp_q.push_back(seg_t'{1'b1, sp, 1'b0});
                    total += M + sp;
                end
                exp_q.push_back(seg_t'{1'b0, M, 1'b0});
                exp_q.push_back(seg_t'{1'b1, ST, 1'b1});
                data_q.push_back(tx_data);
                m_left = total + M + ST + 1;
                n_acc++;
            end
        end
    end

    logic          in_frame = 1'b0;
    logic          lvl = 1'b1;
    int            run = 0;
    logic [DW-1:0] rx = '0;
    int            nbits = 0;

    task automatic end_seg(input logic is_last);
        seg_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_segment", 32'(run), 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("seg_level", 32'(lvl), 32'(e.lvl));
        check("seg_len", 32'(run), 32'(e.len));
        check("seg_last", 32'(is_last), 32'(e.last));
        if (lvl && !is_last) begin
            rx = {rx[DW-2:0], run > 1000};
            nbits++;
        end
    endtask

    // Monitor: measures ir_out runs the way the receiver's pulse-width counter would.
    always @(negedge clk) begin
        if (!reset_n) begin
            in_frame = 1'b0;
`ifdef IR_TX_CARRIER_EN
            check("led_out_reset", 32'(led_out), 32'd0);
`endif
        end else begin
            if (!in_frame) begin
                check("ir_out_frame_start", 32'(ir_out), m_left > 1 ? 32'd0 : 32'd1);
                if (ir_out === 1'b0) begin
                    in_frame = 1'b1;
                    lvl = 1'b0;
                    run = 1;
                    rx = '0;
                    nbits = 0;
                end
            end else if (done === 1'b1 || ir_out !== lvl) begin
                end_seg(done);
                if (done === 1'b1) begin
                    in_frame = 1'b0;
                    check("rx_bits", 32'(nbits), 32'(DW));
                    if (data_q.size() == 0) check("rx_word_unexpected", 32'(rx), 32'd0);
                    else check("rx_word", 32'(rx), 32'(data_q.pop_front()));
                end else begin
                    lvl = ir_out;
                    run = 1;
                end
            end else begin
                run++;
            end
            check("tx_ready", 32'(tx_ready), 32'(m_left <= 1));
            check("busy", 32'(busy), 32'(m_left > 1));
            check("done", 32'(done), 32'(m_left == 1));
`ifdef IR_TX_CARRIER_EN
            check("led_out", 32'(led_out), (in_frame && !lvl) ? 32'((((run - 1) / CH) % 2) == 0) : 32'd0);
`endif
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20000 && m_left != 0; i++) @(negedge clk);
        check("idle_timeout", 32'(m_left), 32'd0);
    endtask

    task automatic send(input logic [DW-1:0] d);
        @(negedge clk);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = DW'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ir_out"}, 32'(ir_out), 32'd1);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int k;
        logic [DW-1:0] w;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 reset_n = 1'b1;

        send(8'hA5);
        wait_idle();

        // Back-to-back: valid held, second word accepted in the done cycle.
        @(negedge clk);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF;
        k = n_acc + 1;
        for (int i = 0; i < 20000 && n_acc < k; i++) @(negedge clk);
        check("b2b_accept", 32'(n_acc), 32'(k));
        tx_valid = 1'b0;
        wait_idle();

        // A valid pulse mid-frame must be ignored.
        send(DW'($urandom));
        repeat (300) @(negedge clk);
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();

        // Reset in the middle of the 4th space.
        w = DW'($urandom);
        send(w);
        k = 4 * M + (w[7] ? S1 : S0) + (w[6] ? S1 : S0) + (w[5] ? S1 : S0) + (w[4] ? S1 : S0) / 2;
        repeat (k - 1) @(negedge clk);
        check("pre_reset_space", 32'(ir_out), 32'd1);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        send(DW'($urandom));
        wait_idle();

        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(DW'($urandom));
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
